// File: rtl/sam_seq_mult.sv
// Iterative shift-and-accumulate multiplier, unsigned or sign-magnitude per transaction.
// Latency max(1, ceil(msb_bits/BPC)) cycles after accept; output held while out_ready is low.
module sam_seq_mult #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic               sign,
  output logic               busy
);

  // Sized with BPC headroom so the final increment never wraps.
  localparam int SW = $clog2(WIDTH + BPC + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand, mplier, mplier_nxt;
  logic [2*WIDTH-1:0] acc, acc_nxt, pp;
  logic [SW-1:0]      shift;
  logic               sgn;

  always_comb begin
    pp         = {{WIDTH{1'b0}}, mcand} * {{(2*WIDTH-BPC){1'b0}}, mplier[BPC-1:0]};
    acc_nxt    = acc + (pp << shift);
    mplier_nxt = mplier >> BPC;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (mplier_nxt == '0) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      shift  <= '0;
      sgn    <= 1'b0;
      prod   <= '0;
      sign   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= mode ? {1'b0, a[WIDTH-2:0]} : a;
            mplier <= mode ? {1'b0, b[WIDTH-2:0]} : b;
            sgn    <= mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            shift  <= '0;
          end
        end
        CALC: begin
          acc    <= acc_nxt;
          mplier <= mplier_nxt;
          shift  <= shift + SW'(BPC);
          // Product is captured once; zero magnitude always reads as positive.
          if (mplier_nxt == '0) begin
            prod <= acc_nxt;
            sign <= sgn & (acc_nxt != '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sam_seq_mult.sv
// Directed bench for sam_seq_mult: one BPC=1 and one BPC=4 instance, WIDTH=32.
module tb_sam_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        mode;
  logic        out_ready;

  logic        in_valid1, in_ready1, out_valid1, sign1, busy1;
  logic [63:0] prod1;
  logic        in_valid4, in_ready4, out_valid4, sign4, busy4;
  logic [63:0] prod4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sam_seq_mult #(.WIDTH(32), .BPC(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid1), .out_ready(out_ready),
    .prod(prod1), .sign(sign1), .busy(busy1)
  );

  sam_seq_mult #(.WIDTH(32), .BPC(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid4), .out_ready(out_ready),
    .prod(prod4), .sign(sign4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic ov(input bit f);
    return f ? out_valid4 : out_valid1;
  endfunction
  function automatic logic ir(input bit f);
    return f ? in_ready4 : in_ready1;
  endfunction
  function automatic logic bz(input bit f);
    return f ? busy4 : busy1;
  endfunction
  function automatic logic [63:0] pr(input bit f);
    return f ? prod4 : prod1;
  endfunction
  function automatic logic sg(input bit f);
    return f ? sign4 : sign1;
  endfunction

  task automatic set_iv(input bit f, input logic v);
    if (f) in_valid4 = v;
    else   in_valid1 = v;
  endtask

  // One transaction with out_ready=1; checks latency, result and one-cycle pulse.
  task automatic txn(input string tag, input bit f, input logic [31:0] ta, input logic [31:0] tb,
                     input logic tm, input logic [63:0] ep, input logic es, input int el);
    int lat;
    a = ta; b = tb; mode = tm;
    set_iv(f, 1'b1);
    @(posedge clk); #1;
    set_iv(f, 1'b0);
    chk({tag, "_busy"}, 64'(bz(f)), 64'd1);
    lat = 0;
    while (!ov(f) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(el));
    chk({tag, "_prod"}, pr(f), ep);
    chk({tag, "_sign"}, 64'(sg(f)), 64'(es));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'(ov(f)), 64'd0);
    chk({tag, "_rdy"}, 64'(ir(f)), 64'd1);
  endtask

  initial begin
    int lat;
    rst = 1'b1; a = '0; b = '0; mode = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_valid4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov",   64'(out_valid1), 64'd0);
    chk("rst_ir",   64'(in_ready1),  64'd1);
    chk("rst_busy", 64'(busy1),      64'd0);
    chk("rst_prod", prod1,           64'd0);
    chk("rst_sign", 64'(sign1),      64'd0);
    chk("rst_ov4",  64'(out_valid4), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    txn("sm_3x5",    1'b0, 32'd3,        32'd5,        1'b1, 64'd15, 1'b0, 3);
    txn("sm_neg",    1'b0, 32'h80000003, 32'h00000005, 1'b1, 64'd15, 1'b1, 3);
    txn("sm_negz",   1'b0, 32'h80000000, 32'h80000007, 1'b1, 64'd0,  1'b0, 3);
    txn("u_max",     1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 1'b0, 32);
    txn("sm_max",    1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h3FFFFFFF00000001, 1'b0, 31);
    txn("u_bzero",   1'b0, 32'd1234,     32'd0,        1'b0, 64'd0,  1'b0, 1);
    txn("b4_u",      1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 64'h0B00EA4E242D2080, 1'b0, 8);
    txn("b4_bzero",  1'b1, 32'h12345678, 32'd0,        1'b0, 64'd0,  1'b0, 1);
    txn("b4_sm_max", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h3FFFFFFF00000001, 1'b0, 8);
    txn("b4_sm_neg", 1'b1, 32'h80000006, 32'h00000007, 1'b1, 64'd42, 1'b1, 1);

    // Backpressure, with in_valid held high through CALC and DONE.
    out_ready = 1'b0;
    a = 32'h80000003; b = 32'h00000005; mode = 1'b1;
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    a = 32'd7; b = 32'd9; mode = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_lat",  64'(lat),   64'd3);
    chk("bp_prod", prod1,      64'd15);
    chk("bp_sign", 64'(sign1), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_ov",   64'(out_valid1), 64'd1);
      chk("bp_hold_prod", prod1,           64'd15);
      chk("bp_hold_sign", 64'(sign1),      64'd1);
      chk("bp_hold_ir",   64'(in_ready1),  64'd0);
    end
    in_valid1 = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_ov", 64'(out_valid1), 64'd0);
    chk("bp_rel_ir", 64'(in_ready1),  64'd1);
    chk("bp_keep",   prod1,           64'd15);

    // Asynchronous reset two cycles into a long CALC.
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; mode = 1'b0;
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", 64'(busy1), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_ov",   64'(out_valid1), 64'd0);
    chk("arst_ir",   64'(in_ready1),  64'd1);
    chk("arst_prod", prod1,           64'd0);
    chk("arst_busy", 64'(busy1),      64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    txn("post_rst", 1'b0, 32'd3, 32'd5, 1'b1, 64'd15, 1'b0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
